cp0_unit: RTL and testbench
===========================

# cp0_unit

Coprocessor-0 exception/interrupt unit for the single-cycle MIPS core, sitting directly downstream of `ctr_unit`. It consumes `iscop0` and `issyscall` from `ctr_unit`, and the `rs`/`rd`/`func` fields of the current instruction. It holds Status, Cause and EPC and synchronizes external interrupt lines. It tells the fetch stage when to redirect to the handler (`exc_take`) or return from it (`eret`).

## Interface
- `HANDLER_ADDR`, default 32'h0000_3000: exception/interrupt handler entry PC.
- `NUM_IRQ`, default 3: external interrupt lines; maps to Status.IM/Cause.IP bits [7+NUM_IRQ:8]; max 6.
- `clk`, in, 1: single clock; all state updates on posedge.
- `rst`, in, 1: synchronous, active-high reset.
- `iscop0`, in, 1: current instruction is a COP0 instruction, from `ctr_unit`.
- `issyscall`, in, 1: current instruction is SYSCALL, from `ctr_unit`.
- `cop0_op`, in, 5: instruction `rs` field. 00000 = MFC0, 00100 = MTC0, 10000 = CO (ERET when `func` = 011000).
- `func`, in, 6: instruction `func` field.
- `cp0_sel`, in, 5: instruction `rd` field. 12 = Status, 13 = Cause, 14 = EPC; others read 0 and ignore writes.
- `wdata`, in, 32: `rt` register value for MTC0.
- `pc`, in, 32: PC of the current instruction.
- `irq`, in, NUM_IRQ: asynchronous level interrupt requests.
- `rdata`, out, 32: MFC0 read data, combinational from `cp0_sel`.
- `exc_take`, out, 1: take an exception this cycle. The core suppresses the current instruction's register and memory writes, and the next PC is `exc_pc`.
- `exc_pc`, out, 32: constant `HANDLER_ADDR`.
- `eret`, out, 1: the current instruction is ERET and is not pre-empted. The next PC is `epc_out`.
- `epc_out`, out, 32: current EPC.

## Operation
- **Status register fields:** [0] IE (global enable), [1] EXL (in-handler), [15:8] IM (interrupt mask). Other bits read 0.
- **Cause register fields:** [6:2] ExcCode (0 = Int, 8 = Sys), [15:8] IP (interrupt pending). Other bits read 0.
- **EPC:** full 32 bits, read/write.
- **IRQ path:** `irq` passes through a 2-flop synchronizer (s1, s2) followed by a delay flop s3.
  - The set condition `s2 & ~s3` sets the sticky IP bit.
  - IP bits are cleared only by MTC0 to Cause, or by reset.
- **Interrupt request:** `int_req = IE & ~EXL & |(IP & IM)`.
- **`exc_take`:** combinational, `issyscall | int_req`.
- **Priority on take:** SYSCALL has priority. ExcCode = 8 if `issyscall`, else 0.
- **On a take edge:**
  - EPC <= `pc`; the instruction is re-executed or skipped by the handler.
  - EXL <= 1.
  - ExcCode is updated.
  - Any pending interrupt stays in IP.
- **MFC0:** `rdata` = selected register; the core writes it to `rt`.
- **MTC0** (`iscop0 & cop0_op==00100 & ~exc_take`) writes on the next edge:
  - Status: bits [1:0] and [15:8] are writable.
  - Cause: only IP is writable.
  - EPC: all 32 bits are writable.
- **ERET** (`iscop0 & cop0_op==10000 & func==011000`):
  - `eret` = decode `& ~exc_take`.
  - The edge clears EXL.
  - While EXL=1, `int_req` = 0, so ERET is never pre-empted by an interrupt.
- **Simultaneous events:**
  - IP set and an MTC0 Cause write on the same edge: the new IP is `wdata[15:8] | set`, so no edge is lost.
  - SYSCALL and an interrupt in the same cycle: SYSCALL is taken and the interrupt remains pending.
  - MTC0 while an interrupt is taken: the write is suppressed.
- **Undefined inputs:** unknown or undefined COP0 encodings have no effect.

## Timing
- **Reset** (edge with `rst`=1):
  - Status, Cause, EPC, s1/s2/s3 all become 0.
  - Hence `exc_take`=0, `eret`=0, `rdata`=0, and `epc_out`=0.
  - Reset overrides any take, MTC0 or ERET in the same cycle.
- **IRQ latency:** `irq` rising before edge k sets IP at edge k+2. `exc_take` is asserted in the cycle after edge k+2 if enabled and masked-in.
- **Same-cycle outputs:** `exc_take` and `eret` are combinational in the cycle of the causing instruction. Register effects are visible after the next edge.
- **MTC0:** `rdata` reflects the written value in the cycle after the MTC0 edge.
- **Interrupt level:** an `irq` level held high causes only one IP set (edge-triggered).

## Test plan
- **Reset:** hold `rst` 2 cycles with `irq`=3'b111 -> `rdata`=0 for sel 12/13/14, `exc_take`=0, `epc_out`=0.
- **SYSCALL:** `pc`=0x0000_0040, `issyscall`=1 -> `exc_take`=1 and `exc_pc`=0x3000. Next cycle: EPC=0x40, Status[1]=1, Cause[6:2]=8.
- **Interrupt:** MTC0 Status=0x0000_0101, then pulse `irq[0]` before edge k.
  - `exc_take`=1 only from the cycle after edge k+2.
  - Cause=0x0000_0100, EPC = `pc` of that cycle.
- **ERET:** with EXL=1, `irq[1]` pending and IM[9]=1, issue ERET -> `eret`=1, `exc_take`=0, `epc_out`=EPC. Next cycle: EXL=0 and `exc_take`=1.
- **SYSCALL and interrupt together:** enabled pending interrupt and `issyscall`=1 in the same cycle -> ExcCode=8 and IP bit still set afterwards.
- **IP clear vs. new edge:** MTC0 Cause=0 on the same edge as a new `irq[2]` set -> Cause reads 0x0000_0400.

Source files
------------

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the single-cycle MIPS core: Status/Cause/EPC, IRQ synchronizer,
// SYSCALL/interrupt take, MFC0/MTC0 access and ERET return.
module cp0_unit #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_3000,
  parameter int          NUM_IRQ      = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               iscop0_i,
  input  logic               issyscall_i,
  input  logic [4:0]         cop0_op_i,
  input  logic [5:0]         func_i,
  input  logic [4:0]         cp0_sel_i,
  input  logic [31:0]        wdata_i,
  input  logic [31:0]        pc_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [31:0]        rdata_o,
  output logic               exc_take_o,
  output logic [31:0]        exc_pc_o,
  output logic               eret_o,
  output logic [31:0]        epc_out_o
);

  localparam logic [7:0] IP_MASK = 8'((9'd1 << NUM_IRQ) - 9'd1);

  logic               ie_q, ie_d;
  logic               exl_q, exl_d;
  logic [7:0]         im_q, im_d;
  logic [4:0]         exccode_q, exccode_d;
  logic [7:0]         ip_q, ip_d;
  logic [31:0]        epc_q, epc_d;
  logic [NUM_IRQ-1:0] s1_q, s2_q, s3_q;

  logic [7:0] ip_set_s;
  logic       int_req_s;
  logic       exc_take_s;
  logic       mtc0_s;
  logic       eret_dec_s;

  // A rising synchronized level sets IP once, however long irq stays high.
  assign ip_set_s   = 8'(s2_q & ~s3_q);
  assign int_req_s  = ie_q & ~exl_q & (|(ip_q & im_q));
  assign exc_take_s = issyscall_i | int_req_s;
  assign mtc0_s     = iscop0_i & (cop0_op_i == 5'b00100) & ~exc_take_s;
  assign eret_dec_s = iscop0_i & (cop0_op_i == 5'b10000) & (func_i == 6'b011000);

  assign exc_take_o = exc_take_s;
  assign exc_pc_o   = HANDLER_ADDR;
  assign eret_o     = eret_dec_s & ~exc_take_s;
  assign epc_out_o  = epc_q;

  // Next-state for Status/Cause/EPC: take beats MTC0 beats ERET.
  always_comb begin
    ie_d      = ie_q;
    exl_d     = exl_q;
    im_d      = im_q;
    exccode_d = exccode_q;
    ip_d      = ip_q | ip_set_s;
    epc_d     = epc_q;
    if (exc_take_s) begin
      epc_d     = pc_i;
      exl_d     = 1'b1;
      exccode_d = issyscall_i ? 5'd8 : 5'd0;
    end else if (mtc0_s) begin
      case (cp0_sel_i)
        5'd12: begin
          ie_d  = wdata_i[0];
          exl_d = wdata_i[1];
          im_d  = wdata_i[15:8];
        end
        5'd13:   ip_d  = (wdata_i[15:8] & IP_MASK) | ip_set_s;
        5'd14:   epc_d = wdata_i;
        default: epc_d = epc_q;
      endcase
    end else if (eret_dec_s) begin
      exl_d = 1'b0;
    end else begin
      exl_d = exl_q;
    end
  end

  // State registers and IRQ synchronizer with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ie_q      <= 1'b0;
      exl_q     <= 1'b0;
      im_q      <= 8'd0;
      exccode_q <= 5'd0;
      ip_q      <= 8'd0;
      epc_q     <= 32'd0;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
    end else begin
      ie_q      <= ie_d;
      exl_q     <= exl_d;
      im_q      <= im_d;
      exccode_q <= exccode_d;
      ip_q      <= ip_d;
      epc_q     <= epc_d;
      s1_q      <= irq_i;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
    end
  end

  // MFC0 read mux; unmapped selectors read zero.
  always_comb begin
    rdata_o = 32'd0;
    case (cp0_sel_i)
      5'd12:   rdata_o = {16'd0, im_q, 6'd0, exl_q, ie_q};
      5'd13:   rdata_o = {16'd0, ip_q, 1'b0, exccode_q, 2'b00};
      5'd14:   rdata_o = epc_q;
      default: rdata_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: a directed cycle table followed by randomized traffic
// compared against an architectural model of Status/Cause/EPC.
module tb_cp0_unit;

  localparam logic [4:0] OP_MT = 5'd4;
  localparam logic [4:0] OP_CO = 5'd16;
  localparam logic [5:0] FN_ER = 6'h18;

  logic        clk = 1'b0;
  logic        rst;
  logic        iscop0, issyscall;
  logic [4:0]  cop0_op;
  logic [5:0]  func;
  logic [4:0]  cp0_sel;
  logic [31:0] wdata, pc;
  logic [2:0]  irq;
  logic [31:0] rdata, exc_pc, epc_out;
  logic        exc_take, eret;

  int errors = 0;
  int checks = 0;

  cp0_unit #(.HANDLER_ADDR(32'h0000_3000), .NUM_IRQ(3)) dut (
    .clk_i(clk), .rst_i(rst), .iscop0_i(iscop0), .issyscall_i(issyscall),
    .cop0_op_i(cop0_op), .func_i(func), .cp0_sel_i(cp0_sel), .wdata_i(wdata),
    .pc_i(pc), .irq_i(irq), .rdata_o(rdata), .exc_take_o(exc_take),
    .exc_pc_o(exc_pc), .eret_o(eret), .epc_out_o(epc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, cop, sys;
    logic [4:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sel;
    logic [31:0] wd, pc;
    logic [2:0]  irq;
    logic        e_take, e_eret;
    logic [31:0] e_rdata, e_epc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic c, input logic s, input logic [4:0] o,
                     input logic [5:0] f, input logic [4:0] sl, input logic [31:0] w,
                     input logic [31:0] p, input logic [2:0] q, input logic et,
                     input logic ee, input logic [31:0] er, input logic [31:0] ep);
    vec_t v;
    v.rst = r; v.cop = c; v.sys = s; v.op = o; v.fn = f; v.sel = sl; v.wd = w;
    v.pc = p; v.irq = q; v.e_take = et; v.e_eret = ee; v.e_rdata = er; v.e_epc = ep;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic s, input logic [4:0] o,
                       input logic [5:0] f, input logic [4:0] sl, input logic [31:0] w,
                       input logic [31:0] p, input logic [2:0] q);
    rst = r; iscop0 = c; issyscall = s; cop0_op = o; func = f;
    cp0_sel = sl; wdata = w; pc = p; irq = q;
  endtask

  // Architectural model: registers as the software sees them, plus irq sample history.
  logic [31:0] m_status, m_cause, m_epc;
  logic [2:0]  m_hist[3];

  function automatic logic m_int_req();
    return m_status[0] & ~m_status[1] & (|(m_cause[15:8] & m_status[15:8]));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] sl);
    case (sl)
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_edge();
    logic [7:0] ip;
    logic [7:0] rise;
    logic       take;
    if (rst) begin
      m_status = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
      for (int i = 0; i < 3; i++) m_hist[i] = 3'd0;
    end else begin
      take = issyscall | m_int_req();
      rise = {5'd0, m_hist[1] & ~m_hist[2]};
      ip   = m_cause[15:8] | rise;
      if (take) begin
        m_epc      = pc;
        m_status   = m_status | 32'h2;
        m_cause    = {16'd0, 8'd0, 1'b0, (issyscall ? 5'd8 : 5'd0), 2'b00};
      end else if (iscop0 && cop0_op == OP_MT) begin
        if (cp0_sel == 5'd12) m_status = wdata & 32'h0000_FF03;
        if (cp0_sel == 5'd13) ip = (wdata[15:8] & 8'h07) | rise;
        if (cp0_sel == 5'd14) m_epc = wdata;
      end else if (iscop0 && cop0_op == OP_CO && func == FN_ER) begin
        m_status = m_status & ~32'h2;
      end
      m_cause[15:8] = ip;
      m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = irq;
    end
  endtask

  initial begin
    // Directed sequence: reset, SYSCALL, interrupt latency, ERET, IP clear race,
    // SYSCALL+IRQ, MTC0 suppressed by a take, undefined encodings.
    add(1,0,0,0,0,    12,0,0,7,            0,0,32'h0,32'h0);
    add(1,0,0,0,0,    13,0,0,7,            0,0,32'h0,32'h0);
    add(0,0,0,0,0,    14,0,0,0,            0,0,32'h0,32'h0);
    add(0,0,1,0,0,    12,0,32'h40,0,       1,0,32'h0,32'h0);
    add(0,0,0,0,0,    12,0,0,0,            0,0,32'h2,32'h40);
    add(0,0,0,0,0,    13,0,0,0,            0,0,32'h20,32'h40);
    add(0,0,0,0,0,    14,0,0,0,            0,0,32'h40,32'h40);
    add(0,1,0,OP_CO,FN_ER,12,0,0,0,        0,1,32'h2,32'h40);
    add(0,0,0,0,0,    12,0,0,0,            0,0,32'h0,32'h40);
    add(0,1,0,OP_MT,0,12,32'h101,0,0,      0,0,32'h0,32'h40);
    add(0,0,0,0,0,    12,0,32'h100,1,      0,0,32'h101,32'h40);
    add(0,0,0,0,0,    13,0,0,0,            0,0,32'h20,32'h40);
    add(0,0,0,0,0,    13,0,0,0,            0,0,32'h20,32'h40);
    add(0,0,0,0,0,    13,0,32'h200,0,      1,0,32'h120,32'h40);
    add(0,0,0,0,0,    13,0,0,0,            0,0,32'h100,32'h200);
    add(0,0,0,0,0,    14,0,0,0,            0,0,32'h200,32'h200);
    add(0,1,0,OP_MT,0,13,32'h0,0,0,        0,0,32'h100,32'h200);
    add(0,1,0,OP_MT,0,12,32'h203,0,2,      0,0,32'h103,32'h200);
    add(0,0,0,0,0,    13,0,0,0,            0,0,32'h0,32'h200);
    add(0,0,0,0,0,    13,0,0,0,            0,0,32'h0,32'h200);
    add(0,0,0,0,0,    13,0,0,0,            0,0,32'h200,32'h200);
    add(0,1,0,OP_CO,FN_ER,12,0,0,0,        0,1,32'h203,32'h200);
    add(0,0,0,0,0,    12,0,32'h300,0,      1,0,32'h201,32'h200);
    add(0,0,0,0,0,    13,0,0,4,            0,0,32'h200,32'h300);
    add(0,0,0,0,0,    13,0,0,4,            0,0,32'h200,32'h300);
    add(0,1,0,OP_MT,0,13,32'h0,0,4,        0,0,32'h200,32'h300);
    add(0,0,0,0,0,    13,0,0,4,            0,0,32'h400,32'h300);
    add(0,0,0,0,0,    13,0,0,4,            0,0,32'h400,32'h300);
    add(0,1,0,OP_MT,0,12,32'h403,0,0,      0,0,32'h203,32'h300);
    add(0,1,0,OP_CO,FN_ER,13,0,0,0,        0,1,32'h400,32'h300);
    add(0,0,1,0,0,    12,0,32'h500,0,      1,0,32'h401,32'h300);
    add(0,0,0,0,0,    13,0,0,0,            0,0,32'h420,32'h500);
    add(0,1,0,OP_CO,FN_ER,14,0,0,0,        0,1,32'h500,32'h500);
    add(0,1,0,OP_MT,0,14,32'hDEAD_BEEF,32'h600,0, 1,0,32'h500,32'h500);
    add(0,0,0,0,0,    14,0,0,0,            0,0,32'h600,32'h600);
    add(0,1,0,5'd2,0, 14,32'h1234,0,0,     0,0,32'h600,32'h600);
    add(0,1,0,OP_MT,0,5'd5,32'hFFFF_FFFF,0,0, 0,0,32'h0,32'h600);
    add(0,0,0,0,0,    12,0,0,0,            0,0,32'h403,32'h600);
    add(0,0,0,0,0,    13,0,0,0,            0,0,32'h400,32'h600);
    add(0,1,0,OP_CO,6'h19,12,0,0,0,        0,0,32'h403,32'h600);
    add(0,0,0,0,0,    12,0,0,0,            0,0,32'h403,32'h600);

    drive(1,0,0,0,0,12,0,0,3'b111);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].cop, tbl[i].sys, tbl[i].op, tbl[i].fn, tbl[i].sel,
            tbl[i].wd, tbl[i].pc, tbl[i].irq);
      #4;
      check($sformatf("vec%0d exc_take", i), {31'd0, exc_take}, {31'd0, tbl[i].e_take});
      check($sformatf("vec%0d eret", i), {31'd0, eret}, {31'd0, tbl[i].e_eret});
      check($sformatf("vec%0d rdata", i), rdata, tbl[i].e_rdata);
      check($sformatf("vec%0d epc_out", i), epc_out, tbl[i].e_epc);
      check($sformatf("vec%0d exc_pc", i), exc_pc, 32'h0000_3000);
      @(posedge clk); #1;
    end

    // Randomized traffic; the first cycle resets DUT and model together.
    begin
      logic [2:0] irq_v;
      logic [4:0] ops[4];
      logic [4:0] sels[5];
      irq_v = 3'd0;
      ops[0] = 5'd0; ops[1] = OP_MT; ops[2] = OP_CO; ops[3] = 5'd0;
      sels[0] = 5'd12; sels[1] = 5'd13; sels[2] = 5'd14; sels[3] = 5'd13; sels[4] = 5'd0;
      for (int n = 0; n < 3000; n++) begin
        logic        r, c, s;
        logic [4:0]  o, sl;
        logic [5:0]  f;
        logic [31:0] w;
        for (int b = 0; b < 3; b++)
          if ($urandom_range(0, 9) == 0) irq_v[b] = ~irq_v[b];
        r  = (n == 0) || ($urandom_range(0, 199) == 0);
        s  = ($urandom_range(0, 99) < 6);
        c  = ($urandom_range(0, 99) < 45);
        ops[3] = 5'($urandom);
        o  = ops[$urandom_range(0, 3)];
        sels[4] = 5'($urandom);
        sl = sels[$urandom_range(0, 4)];
        f  = ($urandom_range(0, 1) == 0) ? FN_ER : 6'($urandom);
        w  = $urandom;
        if ($urandom_range(0, 1) == 0) w[1] = 1'b0;
        drive(r, c, s, o, f, sl, w, $urandom, irq_v);
        #4;
        if (n != 0) begin
          check("rnd exc_take", {31'd0, exc_take}, {31'd0, s | m_int_req()});
          check("rnd eret", {31'd0, eret},
                {31'd0, c & (o == OP_CO) & (f == FN_ER) & ~(s | m_int_req())});
          check("rnd rdata", rdata, m_read(sl));
          check("rnd epc_out", epc_out, m_epc);
        end
        @(posedge clk);
        m_edge();
        #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
